// File: rtl/rotl_pipe.sv
// ----------------------------------------------------------------------------
// rotl_pipe -- rotate-left unit with valid/ready handshakes on both sides.
//
// Undoes the datapath's right-rotate barrel shifter: a word that went through
// that shifter with some offset comes back out of this block unchanged when
// given the same offset.
//
//    out_data[i] = in_data[(i - in_offset) mod 2**OFFW]
//
// Build option (macro ROTL_PIPE_EN):
//    defined   : OFFW register stages. Stage k rotates by 2**k when its offset
//                bit is set. Latency OFFW, capacity OFFW words.
//    undefined : one register stage doing the whole rotate combinationally.
//                Latency 1, capacity 1.
//
// Parameters:
//    OFFW       offset width; the data width is 2**OFFW
//
// Ports:
//    clk        rising-edge clock
//    rst_n      asynchronous active-low reset; clears every stage
//    in_data    word to rotate
//    in_offset  rotate-left amount, 0 .. 2**OFFW-1
//    in_valid   producer offers a word
//    in_ready   block takes the offered word this cycle (combinational from
//               out_ready through the stage valid flags)
//    out_data   rotated word, driven straight from the last stage register
//    out_valid  out_data holds a word
//    out_ready  consumer takes out_data this cycle
// ----------------------------------------------------------------------------
module rotl_pipe #(
    parameter int OFFW = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2**OFFW-1:0]   in_data,
    input  logic [OFFW-1:0]      in_offset,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [2**OFFW-1:0]   out_data,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int W = 2**OFFW;

    // Rotate left by 2**k. The shifts are evaluated at W bits, so the bits
    // pushed out on the left come back in on the right.
    function automatic logic [W-1:0] rot_pow2(input logic [W-1:0] x, input int k);
        return (x << (2**k)) | (x >> (W - 2**k));
    endfunction

`ifdef ROTL_PIPE_EN

    // Per-stage registers. off_q[k] holds the offset bits still to be
    // applied downstream, right-aligned, so every stage tests bit 0.
    logic [OFFW-1:0] v_q;
    logic [W-1:0]    d_q   [OFFW];
    logic [OFFW-1:0] off_q [OFFW];

    // What each stage would load from its upstream this cycle.
    logic [OFFW-1:0] up_v;
    logic [W-1:0]    up_d   [OFFW];
    logic [OFFW-1:0] up_off [OFFW];
    logic [W-1:0]    rot_d  [OFFW];

    // rdy[k]: stage k may load this cycle. rdy[OFFW] is the consumer.
    logic [OFFW:0]   rdy;

    always_comb begin
        up_v[0]   = in_valid;
        up_d[0]   = in_data;
        up_off[0] = in_offset;
        for (int k = 1; k < OFFW; k++) begin
            up_v[k]   = v_q[k-1];
            up_d[k]   = d_q[k-1];
            up_off[k] = off_q[k-1];
        end
    end

    always_comb begin
        for (int k = 0; k < OFFW; k++) begin
            rot_d[k] = up_off[k][0] ? rot_pow2(up_d[k], k) : up_d[k];
        end
    end

    // An empty stage always loads, which is what lets bubbles collapse while
    // the consumer is stalled. Evaluated in one block, downstream first.
    always_comb begin
        rdy       = '0;
        rdy[OFFW] = out_ready;
        for (int k = OFFW - 1; k >= 0; k--) begin
            rdy[k] = !v_q[k] || rdy[k+1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int k = 0; k < OFFW; k++) begin
                d_q[k]   <= '0;
                off_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < OFFW; k++) begin
                if (rdy[k]) begin
                    // A load with nothing upstream just empties the stage;
                    // the payload registers keep their old contents.
                    v_q[k] <= up_v[k];
                    if (up_v[k]) begin
                        d_q[k]   <= rot_d[k];
                        off_q[k] <= up_off[k] >> 1;
                    end
                end
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v_q[OFFW-1];
    assign out_data  = d_q[OFFW-1];

`else

    // Full rotate as a log shifter: one conditional 2**k step per offset bit.
    function automatic logic [W-1:0] rotl(input logic [W-1:0] x,
                                          input logic [OFFW-1:0] amt);
        logic [W-1:0] r;
        r = x;
        for (int k = 0; k < OFFW; k++) begin
            if (amt[k]) begin
                r = rot_pow2(r, k);
            end
        end
        return r;
    endfunction

    logic         v_q;
    logic [W-1:0] d_q;

    assign in_ready = !v_q || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= 1'b0;
            d_q <= '0;
        end else if (in_ready) begin
            v_q <= in_valid;
            if (in_valid) begin
                d_q <= rotl(in_data, in_offset);
            end
        end
    end

    assign out_valid = v_q;
    assign out_data  = d_q;

`endif

endmodule
